// File: rtl/slice_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slice_pkg
//  Description : Shared constants for the raycast slice stages: screen size
//                defaults, default colours and the column-plotter state codes.
//                Conditional feature macro used by consumers: SLICE_SHADE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
package slice_pkg;

    // Screen geometry defaults (160x120 VGA adapter resolution)
    localparam int c_screen_w_dflt = 160;
    localparam int c_screen_h_dflt = 120;

    // Default colours shared with the slice calculator and the top level
    localparam logic [2:0] c_ceil_colour  = 3'b001;
    localparam logic [2:0] c_floor_colour = 3'b010;
    localparam logic [2:0] c_shade_colour = 3'b000;
    localparam int         c_shade_thresh_dflt = 30;

    // Column plotter state encoding
    localparam int c_state_w = 2;
    typedef logic [c_state_w-1:0] state_t;

    localparam state_t c_st_idle   = 2'd0;
    localparam state_t c_st_setup  = 2'd1;
    localparam state_t c_st_draw   = 2'd2;
    localparam state_t c_st_finish = 2'd3;

endpackage : slice_pkg
`default_nettype wire

// File: rtl/slice_bounds.sv
`default_nettype none
// ============================================================================
//  Module      : slice_bounds
//  Description : Purely combinational wall-band geometry for one column.
//                Clamps the projected height to the screen height and centres
//                the band on the middle row.
//  Ports       : i_height [7:0]  projected wall height (unsigned)
//                o_h      [7:0]  min(i_height, SCREEN_H)
//                o_top    [7:0]  first wall row (inclusive)
//                o_bot    [7:0]  last wall row + 1 (exclusive)
//  Revision    : 1.0  initial release
// ============================================================================
module slice_bounds
    import slice_pkg::*;
#(
    parameter int SCREEN_H = c_screen_h_dflt
) (
    input  logic [7:0] i_height,
    output logic [7:0] o_h,
    output logic [7:0] o_top,
    output logic [7:0] o_bot
);

    localparam logic [7:0] c_screen_h = 8'(SCREEN_H);
    localparam logic [7:0] c_half_h   = 8'(SCREEN_H / 2);

    logic [7:0] w_h;

    always_comb begin
        w_h = (i_height > c_screen_h) ? c_screen_h : i_height;
    end

    // With h clamped to SCREEN_H, h>>1 never exceeds SCREEN_H/2 and
    // top + h never exceeds SCREEN_H, so 8-bit arithmetic cannot wrap.
    assign o_h   = w_h;
    assign o_top = c_half_h - {1'b0, w_h[7:1]};
    assign o_bot = o_top + w_h;

endmodule : slice_bounds
`default_nettype wire

// File: rtl/slice_column_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : slice_column_plotter
//  Description : Streams one full screen column (ceiling / centred wall band /
//                floor) to the VGA adapter, one pixel per clock, with a
//                start/busy/done handshake. Sequence: IDLE -> SETUP (1 cycle)
//                -> DRAW (SCREEN_H cycles) -> FINISH (1 cycle, done) -> IDLE.
//                Optional macro SLICE_SHADE_EN: walls shorter than
//                SHADE_THRESH are drawn in SHADE_COLOUR.
//  Ports       : clock, reset (sync, active-high)
//                start, column[7:0], height[7:0], wall_colour[2:0]  request
//                x[7:0], y[6:0], colour[2:0], plot                  pixel out
//                busy, done                                         handshake
//  Revision    : 1.0  initial release
// ============================================================================
module slice_column_plotter
    import slice_pkg::*;
#(
    parameter int         SCREEN_W     = c_screen_w_dflt,
    parameter int         SCREEN_H     = c_screen_h_dflt,
    parameter logic [2:0] CEIL_COLOUR  = c_ceil_colour,
    parameter logic [2:0] FLOOR_COLOUR = c_floor_colour,
    parameter int         SHADE_THRESH = c_shade_thresh_dflt,
    parameter logic [2:0] SHADE_COLOUR = c_shade_colour
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] column,
    input  logic [7:0] height,
    input  logic [2:0] wall_colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] c_col_limit = 8'(SCREEN_W);
    localparam logic [6:0] c_last_row  = 7'(SCREEN_H - 1);

    state_t     r_state;
    logic [6:0] r_row;
    logic [7:0] r_col;
    logic [2:0] r_wall;
    logic [7:0] r_h;
    logic [7:0] r_top;
    logic [7:0] r_bot;

    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_colour;
    logic       r_plot;
    logic       r_busy;
    logic       r_done;

    state_t     w_state_nxt;
    logic [6:0] w_row_nxt;
    logic [2:0] w_wall_eff;
    logic [2:0] w_pix_colour;
    logic [7:0] w_h;
    logic [7:0] w_top;
    logic [7:0] w_bot;

    // Geometry is taken from the incoming height and captured together with
    // the request, so SETUP only has to clear the row counter.
    slice_bounds #(
        .SCREEN_H (SCREEN_H)
    ) u_bounds (
        .i_height (height),
        .o_h      (w_h),
        .o_top    (w_top),
        .o_bot    (w_bot)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = c_st_setup;
                end
            end
            c_st_setup: begin
                w_row_nxt   = 7'd0;
                w_state_nxt = c_st_draw;
            end
            c_st_draw: begin
                if (r_row == c_last_row) begin
                    w_state_nxt = c_st_finish;
                end else begin
                    w_row_nxt = r_row + 7'd1;
                end
            end
            c_st_finish: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

`ifdef SLICE_SHADE_EN
    always_comb begin
        w_wall_eff = (r_h < 8'(SHADE_THRESH)) ? SHADE_COLOUR : r_wall;
    end
`else
    logic w_unused_shade;
    assign w_unused_shade = ^{SHADE_COLOUR, 8'(SHADE_THRESH), r_h};

    always_comb begin
        w_wall_eff = r_wall;
    end
`endif

    // Colour of the row that will be on the outputs next cycle.
    always_comb begin
        if ({1'b0, w_row_nxt} < r_top) begin
            w_pix_colour = CEIL_COLOUR;
        end else if ({1'b0, w_row_nxt} < r_bot) begin
            w_pix_colour = w_wall_eff;
        end else begin
            w_pix_colour = FLOOR_COLOUR;
        end
    end

    // Output flops are loaded from next-state values so that they line up
    // with the state they describe while staying fully registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_row    <= 7'd0;
            r_col    <= 8'd0;
            r_wall   <= 3'd0;
            r_h      <= 8'd0;
            r_top    <= 8'd0;
            r_bot    <= 8'd0;
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_colour <= 3'd0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            if ((r_state == c_st_idle) && start) begin
                r_col  <= column;
                r_wall <= wall_colour;
                r_h    <= w_h;
                r_top  <= w_top;
                r_bot  <= w_bot;
            end
            r_busy <= (w_state_nxt != c_st_idle);
            r_done <= (w_state_nxt == c_st_finish);
            // Off-screen columns keep identical timing but never strobe.
            r_plot <= (w_state_nxt == c_st_draw) && (r_col < c_col_limit);
            if (w_state_nxt == c_st_draw) begin
                r_x      <= r_col;
                r_y      <= w_row_nxt;
                r_colour <= w_pix_colour;
            end
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule : slice_column_plotter
`default_nettype wire

// File: tb/tb_slice_column_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slice_column_plotter
//  Description : Self-checking bench for slice_column_plotter. A table of
//                column requests with hand-derived wall bounds, hand-written
//                handshake and reset-abort sequences, and random requests
//                checked cycle by cycle against a screen-level pixel model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_slice_column_plotter;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] column;
    logic [7:0] height;
    logic [2:0] wall_colour;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    slice_column_plotter u_dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .column      (column),
        .height      (height),
        .wall_colour (wall_colour),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int col;
        int hgt;
        int wall;
        int top;
        int bot;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Screen-level picture of a column: ceiling, wall band, floor.
    function automatic int model_colour(int row, int h, int top, int bot, int wall);
        if (row < top) return 1;
        if (row < bot) begin
`ifdef SLICE_SHADE_EN
            if (h < 30) return 0;
`endif
            return wall;
        end
        return 2;
    endfunction

    function automatic int clamp_h(int hgt);
        return (hgt > 120) ? 120 : hgt;
    endfunction

    // k = cycles after the cycle in which start was sampled.
    task automatic check_cycle(int k, int col, int h, int wall, int top, int bot);
        bit on;
        bit vis;
        on  = (k >= 2) && (k <= 121);
        vis = on && (col < 160);
        chk($sformatf("busy@%0d", k), busy, (k >= 1 && k <= 122));
        chk($sformatf("done@%0d", k), done, (k == 122));
        chk($sformatf("plot@%0d", k), plot, vis);
        if (vis) begin
            chk($sformatf("x@%0d", k), x, col);
            chk($sformatf("y@%0d", k), y, k - 2);
            chk($sformatf("colour@row%0d", k - 2), colour,
                model_colour(k - 2, h, top, bot, wall));
        end
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, " x"}, x, 0);
        chk({tag, " y"}, y, 0);
        chk({tag, " colour"}, colour, 0);
        chk({tag, " plot"}, plot, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
    endtask

    // Called at a falling edge with the DUT idle; returns at the falling edge
    // of cycle 123, where the next request may be issued.
    task automatic run_column(int col, int hgt, int wall, int top, int bot);
        column      = 8'(col);
        height      = 8'(hgt);
        wall_colour = 3'(wall);
        start       = 1'b1;
        for (int k = 1; k <= 123; k++) begin
            @(negedge clock);
            start       = 1'b0;
            column      = 8'(col ^ 8'h55);
            height      = 8'(hgt ^ 8'h3c);
            wall_colour = 3'(~wall);
            check_cycle(k, col, clamp_h(hgt), wall, top, bot);
        end
    endtask

    initial begin
        int seen;
        // col, height, wall, expected top, expected bot
        vecs[0] = '{10,  40, 4, 40,  80};
        vecs[1] = '{5,   41, 4, 40,  81};
        vecs[2] = '{0,  200, 5,  0, 120};
        vecs[3] = '{159,  0, 6, 60,  60};
        vecs[4] = '{170, 40, 4, 40,  80};
        vecs[5] = '{0,    1, 7, 60,  61};
        vecs[6] = '{3,  119, 3,  1, 120};
        vecs[7] = '{10,  20, 4, 50,  70};
        vecs[8] = '{10,  30, 4, 45,  75};

        reset       = 1'b1;
        start       = 1'b0;
        column      = 8'd0;
        height      = 8'd0;
        wall_colour = 3'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("idle");

        for (int i = 0; i < 9; i++) begin
            run_column(vecs[i].col, vecs[i].hgt, vecs[i].wall, vecs[i].top, vecs[i].bot);
        end

        // Handshake: starts at cycles 5 and 122 ignored, start at 123 taken.
        column      = 8'd10;
        height      = 8'd40;
        wall_colour = 3'd4;
        start       = 1'b1;
        for (int k = 1; k <= 246; k++) begin
            @(negedge clock);
            if (k <= 123) check_cycle(k, 10, 40, 4, 40, 80);
            else          check_cycle(k - 123, 20, 40, 5, 40, 80);
            start       = (k == 5 || k == 122 || k == 123);
            column      = (k == 123) ? 8'd20 : 8'd99;
            height      = (k == 123) ? 8'd40 : 8'd10;
            wall_colour = (k == 123) ? 3'd5 : 3'd7;
        end

        // Reset in the middle of a column: outputs clear, no done follows.
        column      = 8'd10;
        height      = 8'd40;
        wall_colour = 3'd4;
        start       = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            start = 1'b0;
            check_cycle(k, 10, 40, 4, 40, 80);
        end
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("abort");
        reset = 1'b0;
        seen  = 0;
        for (int k = 0; k < 130; k++) begin
            @(negedge clock);
            if (done || busy || plot) seen++;
        end
        chk("activity after abort", seen, 0);

        // Random requests against the pixel model.
        for (int i = 0; i < 20; i++) begin
            int col, hgt, wall, h;
            col  = int'($urandom_range(0, 200));
            hgt  = int'($urandom_range(0, 255));
            wall = int'($urandom_range(0, 7));
            h    = clamp_h(hgt);
            run_column(col, hgt, wall, 60 - h / 2, 60 - h / 2 + h);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_slice_column_plotter
`default_nettype wire

// File: doc/slice_column_plotter.md
# slice_column_plotter

Downstream stage of the per-column raycast slice calculator. Takes one screen column index plus the projected wall height that stage produces, and streams all 120 pixels of that column to the VGA adapter: ceiling above the wall, wall band centred on row 60, floor below. One pixel per clock, with a start/busy/done handshake so the slice FSM can step to the next column when `done` pulses.

## Interface
Parameters:
- `SCREEN_W`, 160: screen width in pixels; columns at or above this are not drawn.
- `SCREEN_H`, 120: screen height in pixels (rows 0..119).
- `CEIL_COLOUR`, 3'b001: ceiling pixel colour.
- `FLOOR_COLOUR`, 3'b010: floor pixel colour.
- `SHADE_THRESH`, 30: height below which far walls are shaded (only with `SLICE_SHADE_EN`).
- `SHADE_COLOUR`, 3'b000: colour for shaded wall pixels.

Ports:
- `clock`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: request to draw one column; sampled only in IDLE.
- `column`, in, 8: screen x for the request, unsigned.
- `height`, in, 8: projected wall height in pixels, unsigned.
- `wall_colour`, in, 3: wall colour (caller picks horizontal or vertical hit tint).
- `x`, out, 8: pixel x to the VGA adapter.
- `y`, out, 7: pixel y to the VGA adapter.
- `colour`, out, 3: pixel colour.
- `plot`, out, 1: write strobe, one pixel per high cycle.
- `busy`, out, 1: high whenever state is not IDLE.
- `done`, out, 1: one-cycle pulse when the column is finished.

## Operation
- All outputs are registered. Reset values: `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `done`=0, state IDLE.
- States are IDLE, SETUP, DRAW, FINISH.
- IDLE → SETUP on `start`=1. The block latches `column`, `wall_colour` and `h = min(height, SCREEN_H)`.
- SETUP lasts 1 cycle. It computes `top = SCREEN_H/2 − (h>>1)` and `bot = top + h` (exclusive). Widths are 8 bits, with no overflow possible: `top` is 0..60 and `bot` is at most 120. It clears the row counter. Next state is DRAW.
- DRAW lasts SCREEN_H cycles, with the row counter `r` running 0..119.
  - Outputs: `y=r`, `x=column`, `plot=1`.
  - `colour` is CEIL_COLOUR when `r<top`, `wall_colour` when `top≤r<bot`, and FLOOR_COLOUR otherwise.
  - After r=119, next state is FINISH. The counter never wraps inside DRAW.
- FINISH lasts 1 cycle: `done=1`, `plot=0`, then the block returns to IDLE.
- Column ≥ SCREEN_W: the request still runs the full sequence with identical timing, but `plot` stays 0 throughout. `done` pulses as normal.
- h=0: the whole column is ceiling (rows <60) and floor (rows ≥60). There is no wall row.
- `start` while `busy` is ignored, with no queueing. `start` in the same cycle as the FINISH `done` is also ignored. `start` in the cycle after `done` (IDLE) is accepted.
- Reset mid-operation: the block goes to IDLE on the next edge and all outputs take their reset values. The aborted column gets no `done`.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycle 1: SETUP, `busy`=1.
- Cycles 2..121: `plot`=1 with y=0..119.
- Cycle 122: `done`=1.
- Cycle 123: IDLE, `busy`=0.
- Column-to-column throughput is 123 cycles.
- Outputs change only on clock edges; no input reaches an output combinationally.

## Configuration
- `SLICE_SHADE_EN` defined: wall pixels use SHADE_COLOUR instead of `wall_colour` when latched `h < SHADE_THRESH`. This is a distance cue for far walls.
- `SLICE_SHADE_EN` undefined: wall pixels always use `wall_colour`, and the SHADE_* parameters are unused.
- Timing is identical in both builds.

## Structure
- The shared package `slice_pkg` holds:
  - the state enum (IDLE/SETUP/DRAW/FINISH);
  - the SCREEN_W/SCREEN_H defaults;
  - the default colour constants, which are shared with the slice calculator and the top level.
- One sub-module, `slice_bounds`, is purely combinational. It takes `height` and returns the clamped `h`, `top` and `bot`, and is reused by any future texture stage.

## Test plan
- Basic column: column=10, height=40, wall=3'b100. Expect 120 plot strobes at x=10: y 0..39 colour 001, y 40..79 colour 100, y 80..119 colour 010. `done` at cycle 122.
- Odd height: height=41. Expect top=40 and bot=81, so rows 40..80 are wall.
- Clamp and empty: height=200 gives all 120 rows wall. height=0 gives rows 0..59 colour 001 and rows 60..119 colour 010.
- Handshake: re-assert `start` at cycles 5 and 122. Both are ignored (one `done` only). Assert `start` at cycle 123; a second column begins with SETUP at 124.
- Off-screen and reset: column=170 gives `plot` low for all cycles and `done` at 122. Assert `reset` at cycle 60 of a normal column: all outputs are 0 the next cycle and no `done` follows.
- Shade (`SLICE_SHADE_EN` only): height=20, wall=3'b100. Expect rows 50..69 colour 000. With height=30 the same rows are colour 100.
